// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster-order signed pixel stream.
// Half-row partial maxima live in a row buffer; pooled results saturate to OUT_WIDTH bits.
module maxpool2x2_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned IMG_W      = 26,
    parameter int unsigned IMG_H      = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int unsigned PW    = IMG_W / 2;
    localparam int unsigned PH    = IMG_H / 2;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned K_W   = (PW > 1) ? $clog2(PW) : 1;
    localparam logic        ODD_W = (IMG_W % 2) == 1;
    localparam logic        ODD_H = (IMG_H % 2) == 1;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((2 ** OUT_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic signed [DATA_WIDTH-1:0]  pair_q, pair_d;
    logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_last_q, out_last_d;
    logic                          busy_q, busy_d;
    logic                          frame_done_q, frame_done_d;
    logic signed [DATA_WIDTH-1:0]  rowbuf_q [PW];

    logic                          accept;
    logic                          last_col, last_row;
    logic                          col_live, row_live;
    logic [K_W-1:0]                k;
    logic signed [DATA_WIDTH-1:0]  pm, rb_rd, res;
    logic                          rb_we;

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH-1:0] v);
        if (v[DATA_WIDTH-1]) begin
            return '0;
        end else if (v > SAT_MAX) begin
            return '1;
        end
        return OUT_WIDTH'(v);
    endfunction

    assign in_ready_o   = (state_q == RUN) && !start_i && (!out_valid_q || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

    // Trailing odd column/row pixels are consumed but never enter a window.
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    assign col_live = !(ODD_W && last_col);
    assign row_live = !(ODD_H && last_row);
    assign k        = K_W'(col_q >> 1);
    assign rb_rd    = rowbuf_q[k];
    assign pm       = ($signed(in_data_i) > pair_q) ? $signed(in_data_i) : pair_q;
    assign res      = (rb_rd > pm) ? rb_rd : pm;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rb_we        = 1'b0;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // start_i arms a frame from IDLE and aborts/restarts one in progress.
        if (start_i) begin
            col_d       = '0;
            row_d       = '0;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col_d = '0;
                            row_d = last_row ? '0 : row_q + ROW_W'(1);
                            if (last_row) begin
                                state_d = DRAIN;
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end

                        if (col_live && row_live) begin
                            if (!col_q[0]) begin
                                pair_d = $signed(in_data_i);
                            end else if (!row_q[0]) begin
                                rb_we = 1'b1;
                            end else begin
                                out_data_d  = saturate(res);
                                out_valid_d = 1'b1;
                                out_last_d  = (row_q == ROW_W'(2 * PH - 1)) &&
                                              (col_q == COL_W'(2 * PW - 1));
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || out_ready_i) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row buffer holds even-row pair maxima; every entry is written before it is read.
    always_ff @(posedge clk_i) begin
        if (rb_we) begin
            rowbuf_q[k] <= pm;
        end
    end

endmodule
